// File: rtl/seq_pkg.sv
// Shared types and constants for the exec_sequencer block.
`timescale 1ns/1ps
package seq_pkg;

    // Sequencer phases for one instruction
    typedef enum logic [3:0] {
        BOOT     = 4'd0,
        IF_REQ   = 4'd1,
        IF_WAIT  = 4'd2,
        EXEC     = 4'd3,
        MEM_REQ  = 4'd4,
        MEM_WAIT = 4'd5,
        WB       = 4'd6,
        HALT     = 4'd7,
        ERR      = 4'd8
    } seq_state_t;

    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    // States that wait on an external handshake and are watched by the watchdog
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == IF_REQ) || (s == IF_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
    endfunction

    // Loads and stores need the data-memory handshake
    function automatic logic is_mem_op(input logic [31:0] i);
        return (i[6:0] == OPC_LOAD) || (i[6:0] == OPC_STORE);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state cycle counter. Counts while en is high, restarts on clr, and
// raises expire_c on the last permitted cycle. TIMEOUT_CYCLES=0 disables it.
// Ports: clk, rst (sync, active-high), clr, en, expire_c.
`timescale 1ns/1ps
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic        ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] count;

    // Counter never passes LAST: expiry always forces a state change, which clears it
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (ENABLED && en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = ENABLED && en && (count == CNT_W'(LAST));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer for the RV32 datapath: fetch, settle, optional
// data-memory access, single-cycle commit. Halts on ebreak, errors on bus timeout.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifu_req_*/ifu_rsp_*            instruction fetch handshake (addr = pc)
//   inst, pc, pc_next              latched instruction, current/next PC
//   reg_we_in, reg_we              regfile write enable, gated to the WB cycle
//   lsu_req_valid/ready, lsu_rsp_valid  data memory handshake
//   halt, err                      ebreak reached / watchdog expired (sticky)
// Optional build macro SEQ_PERF_CNT_EN adds 64-bit mcycle and minstret outputs.
`timescale 1ns/1ps
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned         XLEN           = 32,
    parameter logic [XLEN-1:0]     RESET_PC       = XLEN'(32'h8000_0000),
    parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    output logic            ifu_rsp_ready,
    input  logic [31:0]     ifu_rsp_inst,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    input  logic            reg_we_in,
    output logic            reg_we,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_rsp_valid,
    output logic            halt,
    output logic            err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [63:0]     mcycle,
    output logic [63:0]     minstret
`endif
);

    seq_state_t state;
    seq_state_t state_next;
    logic       wd_expire_c;
    logic       wd_en;
    logic       wd_clr;

    assign wd_en  = is_wait_state(state);
    assign wd_clr = (state_next != state);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expire_c(wd_expire_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a handshake completing on the expiry cycle takes priority over ERR
    always_comb begin
        state_next = state;
        case (state)
            BOOT:     state_next = IF_REQ;
            IF_REQ: begin
                if (ifu_req_ready)    state_next = IF_WAIT;
                else if (wd_expire_c) state_next = ERR;
            end
            IF_WAIT: begin
                if (ifu_rsp_valid)    state_next = EXEC;
                else if (wd_expire_c) state_next = ERR;
            end
            EXEC: begin
                if (inst == INST_EBREAK) state_next = HALT;
                else if (is_mem_op(inst)) state_next = MEM_REQ;
                else                      state_next = WB;
            end
            MEM_REQ: begin
                if (lsu_req_ready)    state_next = MEM_WAIT;
                else if (wd_expire_c) state_next = ERR;
            end
            MEM_WAIT: begin
                if (lsu_rsp_valid)    state_next = WB;
                else if (wd_expire_c) state_next = ERR;
            end
            WB:       state_next = IF_REQ;
            HALT:     state_next = HALT;
            ERR:      state_next = ERR;
            default:  state_next = BOOT;
        endcase
    end

    // Moore handshake outputs, registered from the next state so they align with state
    always_ff @(posedge clk) begin
        if (rst) begin
            ifu_req_valid <= 1'b0;
            ifu_rsp_ready <= 1'b0;
            lsu_req_valid <= 1'b0;
            halt          <= 1'b0;
            err           <= 1'b0;
        end else begin
            ifu_req_valid <= (state_next == IF_REQ);
            ifu_rsp_ready <= (state_next == IF_WAIT);
            lsu_req_valid <= (state_next == MEM_REQ);
            halt          <= (state_next == HALT);
            err           <= (state_next == ERR);
        end
    end

    // Write enable follows the control unit only during the commit cycle
    assign reg_we = (state == WB) && reg_we_in;

    // PC commits at WB exit; instruction latches on fetch completion
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= INST_NOP;
        end else begin
            if (state == WB) begin
                pc <= pc_next;
            end
            if ((state == IF_WAIT) && ifu_rsp_valid) begin
                inst <= ifu_rsp_inst;
            end
        end
    end

    assign ifu_req_addr = pc;

`ifdef SEQ_PERF_CNT_EN
    // Cycle and retired-instruction counters; ebreak retires on entry to HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if ((state != BOOT) && (state != HALT) && (state != ERR)) begin
                mcycle <= mcycle + 64'd1;
            end
            if ((state == WB) || ((state == EXEC) && (state_next == HALT))) begin
                minstret <= minstret + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
`timescale 1ns/1ps
module tb_exec_sequencer;

    localparam int unsigned TO     = 16;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] LOADI  = 32'h0000_2103;
    localparam logic [31:0] STOREI = 32'h0020_2023;

    // Model phases, one per spec state
    localparam int M_BOOT = 0, M_IFREQ = 1, M_IFWAIT = 2, M_EXEC = 3, M_MEMREQ = 4,
                   M_MEMWAIT = 5, M_WB = 6, M_HALT = 7, M_ERR = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_inst, inst, pc, pc_next;
    logic        reg_we_in, reg_we;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        halt, err;
`ifdef SEQ_PERF_CNT_EN
    logic [63:0] mcycle, minstret;
`endif

    exec_sequencer #(
        .XLEN(32),
        .RESET_PC(32'h8000_0000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_inst(ifu_rsp_inst),
        .inst(inst), .pc(pc), .pc_next(pc_next),
        .reg_we_in(reg_we_in), .reg_we(reg_we),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .halt(halt), .err(err)
`ifdef SEQ_PERF_CNT_EN
        , .mcycle(mcycle), .minstret(minstret)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int reg_we_cnt = 0, lsu_cnt = 0, ifreq_cnt = 0;
    int req_cyc = 0, req_cyc_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ph = M_BOOT;
    int          mw = 0;
    logic [31:0] mpc = RST_PC;
    logic [31:0] minst = NOP;
    logic [63:0] mcyc = 0, mret = 0;

    function automatic bit waiting(input int p);
        return (p == M_IFREQ) || (p == M_IFWAIT) || (p == M_MEMREQ) || (p == M_MEMWAIT);
    endfunction

    always @(posedge clk) begin : model_and_compare
        int nph;
        bit go;
        logic [5:0] e_hs, a_hs;
        if (rst) begin
            ph = M_BOOT; mpc = RST_PC; minst = NOP; mw = 0; mcyc = 0; mret = 0;
        end else begin
            nph = ph;
            go  = 1'b0;
            case (ph)
                M_BOOT:    nph = M_IFREQ;
                M_IFREQ:   begin go = ifu_req_ready; if (go) nph = M_IFWAIT; end
                M_IFWAIT:  begin go = ifu_rsp_valid; if (go) begin nph = M_EXEC; minst = ifu_rsp_inst; end end
                M_EXEC: begin
                    if (minst == EBREAK) nph = M_HALT;
                    else if (minst[6:0] == 7'b0000011 || minst[6:0] == 7'b0100011) nph = M_MEMREQ;
                    else nph = M_WB;
                end
                M_MEMREQ:  begin go = lsu_req_ready; if (go) nph = M_MEMWAIT; end
                M_MEMWAIT: begin go = lsu_rsp_valid; if (go) nph = M_WB; end
                M_WB:      begin mpc = pc_next; nph = M_IFREQ; end
                default:   nph = ph;
            endcase
            if (waiting(ph) && !go && mw == int'(TO) - 1) nph = M_ERR;
            if (ph != M_BOOT && ph != M_HALT && ph != M_ERR) mcyc = mcyc + 64'd1;
            if (ph == M_WB || (ph == M_EXEC && nph == M_HALT)) mret = mret + 64'd1;
            mw = (waiting(ph) && nph == ph) ? mw + 1 : 0;
            ph = nph;
        end
        cyc++;
        #1;
        e_hs = {ph == M_IFREQ, ph == M_IFWAIT, ph == M_MEMREQ,
                (ph == M_WB) && reg_we_in, ph == M_HALT, ph == M_ERR};
        a_hs = {ifu_req_valid, ifu_rsp_ready, lsu_req_valid, reg_we, halt, err};
        checks++;
        if (a_hs !== e_hs || pc !== mpc || ifu_req_addr !== mpc || inst !== minst) begin
            errors++;
            $display("FAIL cycle%0d outputs actual hs=%b pc=%h addr=%h inst=%h required hs=%b pc=%h addr=%h inst=%h",
                     cyc, a_hs, pc, ifu_req_addr, inst, e_hs, mpc, mpc, minst);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (mcycle !== mcyc || minstret !== mret) begin
            errors++;
            $display("FAIL cycle%0d perf actual mcycle=%0d minstret=%0d required mcycle=%0d minstret=%0d",
                     cyc, mcycle, minstret, mcyc, mret);
        end
`endif
        if (reg_we === 1'b1) reg_we_cnt++;
        if (lsu_req_valid === 1'b1) lsu_cnt++;
        if (ifu_req_valid === 1'b1) ifreq_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_out(input int sel, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if ((sel == 0 && ifu_req_valid === 1'b1) || (sel == 1 && lsu_req_valid === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req sel=%0d actual=timeout required=request within 64 cycles", sel);
        end
    endtask

    task automatic fetch(input logic [31:0] i, input logic [31:0] addr_exp, input logic [31:0] pcn,
                         input logic we, input int req_dly, input int rsp_dly);
        bit ok;
        wait_out(0, ok);
        if (!ok) return;
        check("fetch_addr", ifu_req_addr, addr_exp);
        req_cyc_prev = req_cyc;
        req_cyc      = cyc;
        pc_next      = pcn;
        reg_we_in    = we;
        repeat (req_dly) @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        repeat (rsp_dly) @(negedge clk);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = i;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = $urandom;
    endtask

    task automatic mem(input int req_dly, input int rsp_dly);
        bit ok;
        wait_out(1, ok);
        if (!ok) return;
        repeat (req_dly) @(negedge clk);
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        repeat (rsp_dly) @(negedge clk);
        lsu_rsp_valid = 1'b1;
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int we0, lsu0, ifq0;
        bit ok;
        rst = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'h0;
        pc_next = 32'h0; reg_we_in = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, NOP);
        check("rst_outputs", 32'({ifu_req_valid, ifu_rsp_ready, lsu_req_valid, reg_we, halt, err}), 32'h0);
        rst = 1'b0;

        // 1: back-to-back addi, 4 cycles each
        we0 = reg_we_cnt;
        fetch(ADDI, 32'h8000_0000, 32'h8000_0004, 1'b1, 0, 0);
        fetch(ADDI, 32'h8000_0004, 32'h8000_0008, 1'b1, 0, 0);
        check("addi_period", 32'(req_cyc - req_cyc_prev), 32'd4);
        check("addi_we_once", 32'(reg_we_cnt - we0), 32'd1);

        // 2: load with delayed lsu handshake
        fetch(LOADI, 32'h8000_0008, 32'h8000_000C, 1'b1, 0, 0);
        lsu0 = lsu_cnt; we0 = reg_we_cnt;
        mem(3, 1);
        check("load_we_in_wb", 32'(reg_we), 32'd1);
        check("load_lsu_valid_cycles", 32'(lsu_cnt - lsu0), 32'd4);
        check("load_we_once", 32'(reg_we_cnt - we0), 32'd1);

        // 3: store with reg_we_in=0
        fetch(STOREI, 32'h8000_000C, 32'h8000_0010, 1'b0, 2, 1);
        we0 = reg_we_cnt;
        mem(1, 2);
        @(negedge clk);
        check("store_no_we", 32'(reg_we_cnt - we0), 32'd0);
        check("store_pc_adv", pc, 32'h8000_0010);

        // 5a: ready arrives on the last permitted cycle; transition wins
        fetch(ADDI, 32'h8000_0010, 32'h8000_0014, 1'b1, 15, 0);
        check("wd_edge_no_err", 32'(err), 32'd0);

        // 5b: ready held low -> err after 16 IF_REQ cycles, sticky
        wait_out(0, ok);
        check("wd_addr", ifu_req_addr, 32'h8000_0014);
        repeat (15) @(negedge clk);
        check("wd_cycle16_still_req", 32'({ifu_req_valid, err}), 32'b10);
        @(negedge clk);
        check("wd_err_set", 32'({ifu_req_valid, err}), 32'b01);
        repeat (20) @(negedge clk);
        check("wd_err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared_by_rst", 32'(err), 32'd0);

        // 6: reset mid MEM_WAIT, stray response afterwards
        fetch(LOADI, 32'h8000_0000, 32'h8000_0004, 1'b1, 0, 0);
        wait_out(1, ok);
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lsu_rsp_valid = 1'b1;
        check("rst_mid_pc", pc, RST_PC);
        check("rst_mid_lsu", 32'(lsu_req_valid), 32'd0);
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
        check("stray_ignored", 32'({lsu_req_valid, ifu_req_valid}), 32'b01);

        // 4: ebreak halts, no further requests, pc frozen
        fetch(EBREAK, 32'h8000_0000, 32'h8000_0004, 1'b0, 0, 0);
        check("halt_in_exec", 32'(halt), 32'd0);
        @(negedge clk);
        check("halt_set", 32'(halt), 32'd1);
        ifq0 = ifreq_cnt;
        repeat (100) @(negedge clk);
        check("halt_no_fetch", 32'(ifreq_cnt - ifq0), 32'd0);
        check("halt_pc_frozen", pc, RST_PC);
        check("halt_sticky", 32'({halt, err}), 32'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle sequencer for the RV32 core datapath. Fetches each instruction over a valid/ready instruction-memory port and holds it stable for the combinational decode/ALU datapath. Steps load/store instructions through a data-memory handshake, then gates register write-back and PC update to a single commit cycle. Halts on ebreak and flags a bus watchdog timeout.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 1024, maximum cycles in any wait state; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_req_addr  out  XLEN  fetch address, equal to pc
ifu_rsp_valid  in  1  fetched instruction valid
ifu_rsp_ready  out  1  sequencer accepts the fetch response
ifu_rsp_inst  in  32  fetched instruction
inst  out  32  latched instruction driven to decode and regfile
pc  out  XLEN  current PC
pc_next  in  XLEN  next PC computed by the datapath (pc+4, branch or jump target)
reg_we_in  in  1  register write enable from the control unit
reg_we  out  1  gated regfile write enable
lsu_req_valid  out  1  data memory request valid
lsu_req_ready  in  1  data memory request accepted
lsu_rsp_valid  in  1  data memory response or store acknowledge
halt  out  1  ebreak reached; the simulation top calls ebreak()
err  out  1  watchdog expired, sticky

Behaviour:
- States: BOOT, IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
- Handshake outputs are Moore decodes of the state:
  - ifu_req_valid = IF_REQ
  - ifu_rsp_ready = IF_WAIT
  - lsu_req_valid = MEM_REQ
  - reg_we = WB & reg_we_in
  - halt = HALT
  - err = ERR
- Reset, registered: state=BOOT, pc=RESET_PC, inst=32'h0000_0013 (nop), watchdog=0. All outputs are therefore 0 while rst is high and in the first cycle after it, except pc and inst.
- BOOT -> IF_REQ unconditionally.
- IF_REQ -> IF_WAIT when ifu_req_ready=1. ifu_rsp_valid is ignored in IF_REQ.
- IF_WAIT: when ifu_rsp_valid=1, inst <= ifu_rsp_inst and the state goes to EXEC.
- EXEC: exactly 1 cycle for the datapath to settle. Next state from inst:
  - inst == 32'h0010_0073 -> HALT
  - inst[6:0] == 7'b0000011 (load) or 7'b0100011 (store) -> MEM_REQ
  - otherwise -> WB
- MEM_REQ -> MEM_WAIT on lsu_req_ready. MEM_WAIT -> WB on lsu_rsp_valid. Stores also wait for the acknowledge.
- WB: 1 cycle. reg_we follows reg_we_in, pc <= pc_next, then -> IF_REQ.
- pc and inst change only at WB exit and at IF_WAIT completion respectively. Both are stable through EXEC/MEM/WB.
- Latency: a non-memory instruction with zero-wait memory takes 4 cycles (IF_REQ, IF_WAIT, EXEC, WB). Loads and stores take at least 6.
- Watchdog:
  - Counts cycles while in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT; clears on every state change.
  - When the count reaches TIMEOUT_CYCLES-1 and the current state's exit condition is still false, next state is ERR.
  - If the exit condition is true in that cycle, the transition wins.
- HALT and ERR are absorbing until rst. No requests are issued, pc is frozen, reg_we=0.
- rst in any state, including mid-handshake: return to BOOT next cycle and drop outstanding requests. A late ifu_rsp_valid or lsu_rsp_valid after reset is ignored, because it is not sampled outside IF_WAIT/MEM_WAIT.

Optional Feature:
Macro SEQ_PERF_CNT_EN.
- Defined: adds outputs mcycle (64) and minstret (64), both reset to 0.
  - mcycle increments every cycle not in BOOT/HALT/ERR.
  - minstret increments on each WB cycle and on entry to HALT.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package seq_pkg holds:
  - seq_state_t enum typedef
  - constants OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, INST_EBREAK=32'h0010_0073, INST_NOP=32'h0000_0013
- One sub-module, seq_watchdog: parameterised cycle counter with clear, enable and expire outputs.

Test Plan:
1. Reset, ifu ready=1, response one cycle later with 32'h0010_0093 (addi), reg_we_in=1, pc_next=0x8000_0004 -> ifu_req_addr=0x8000_0000, reg_we high for exactly 1 cycle, next ifu_req_addr=0x8000_0004, 4 cycles per instruction.
2. Load 32'h0000_2103 with lsu_req_ready delayed 3 cycles and lsu_rsp_valid 2 cycles after acceptance -> lsu_req_valid held 4 cycles, reg_we asserted only in the single WB cycle after lsu_rsp_valid.
3. Store 32'h0020_2023 with reg_we_in=0 -> reg_we never asserts, pc advances after the acknowledge.
4. Fetch returns 32'h0010_0073 -> halt=1 from the cycle after EXEC; ifu_req_valid stays 0 and pc stays frozen for 100 cycles.
5. TIMEOUT_CYCLES=16, ifu_req_ready held 0 -> err=1 after 16 cycles in IF_REQ, sticky until rst; ready rising in cycle 16 instead advances to IF_WAIT with err=0.
6. rst pulsed during MEM_WAIT, then a stray lsu_rsp_valid -> BOOT, pc=0x8000_0000, lsu_req_valid=0, stray response ignored, fetch restarts at 0x8000_0000.
